// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Vectored, nesting interrupt controller. Raw asynchronous request lines are
// synchronised, turned into pending bits (edge-latched or level-following per
// channel), filtered by a run-time mask and by the in-service priority level,
// and the highest-priority survivor is presented to the CPU as a request with
// its channel id and handler address. Channel N_IRQ-1 has the highest priority.
//
// Ports:
//   clk       in   CPU clock
//   rst       in   asynchronous, active-high reset
//   irq_in    in   [N_IRQ]      raw asynchronous request lines
//   ie        in                global interrupt enable from CPU status
//   int_ack   in                pulse: CPU has taken the presented interrupt
//   int_done  in                pulse: CPU executed ERET
//   cfg_we    in                mask write strobe (also clears lost flags)
//   cfg_mask  in   [N_IRQ]      new mask value, 1 = channel enabled
//   int_req   out               interrupt request to the CPU
//   int_id    out  [ID_WIDTH]   channel being requested
//   int_vec   out  [VEC_WIDTH]  handler address of int_id
//   irw       out  [N_IRQ]      in-service bits (drive the IRW LEDs)
//   pending   out  [N_IRQ]      pending register
//   lost      out  [N_IRQ]      sticky lost-edge flags
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int                   N_IRQ      = 4,
    parameter int                   ID_WIDTH   = 2,
    parameter int                   VEC_WIDTH  = 32,
    parameter logic [VEC_WIDTH-1:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [VEC_WIDTH-1:0] VEC_STRIDE = 32'h0000_0100,
    parameter logic [N_IRQ-1:0]     EDGE_MASK  = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IRQ-1:0]     irq_in,
    input  logic                 ie,
    input  logic                 int_ack,
    input  logic                 int_done,
    input  logic                 cfg_we,
    input  logic [N_IRQ-1:0]     cfg_mask,
    output logic                 int_req,
    output logic [ID_WIDTH-1:0]  int_id,
    output logic [VEC_WIDTH-1:0] int_vec,
    output logic [N_IRQ-1:0]     irw,
    output logic [N_IRQ-1:0]     pending,
    output logic [N_IRQ-1:0]     lost
);

    // Request FSM encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [N_IRQ-1:0]    sync1_q;     // first synchroniser stage
    logic [N_IRQ-1:0]    sync2_q;     // second synchroniser stage (safe level)
    logic [N_IRQ-1:0]    sync3_q;     // previous safe level, for rise detection
    logic [N_IRQ-1:0]    pending_q, pending_d;
    logic [N_IRQ-1:0]    lost_q,    lost_d;
    logic [N_IRQ-1:0]    mask_q,    mask_d;
    logic [N_IRQ-1:0]    irw_q,     irw_d;
    logic [1:0]          state_q,   state_d;
    logic [ID_WIDTH-1:0] int_id_q,  int_id_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [N_IRQ-1:0]    rise;        // synchronised rising edge, edge channels only
    logic                take_ack;    // ack that the FSM actually honours
    logic [N_IRQ-1:0]    ack_sel;     // one-hot of the channel being acknowledged
    logic [N_IRQ-1:0]    done_sel;    // one-hot of the highest in-service bit
    logic [N_IRQ-1:0]    above_irw;   // channel outranks everything in service
    logic [N_IRQ-1:0]    eligible;
    logic                any_eligible;
    logic [ID_WIDTH-1:0] cand_id;

    assign rise     = sync2_q & ~sync3_q & EDGE_MASK;
    assign take_ack = int_ack && (state_q == ST_REQ);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        ack_sel = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_sel[i] = take_ack && (int_id_q == ID_WIDTH'(i));
        end
    end

    // Later (higher) set bits overwrite earlier ones, leaving only the top bit.
    always_comb begin
        done_sel = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (irw_q[i]) begin
                done_sel    = '0;
                done_sel[i] = 1'b1;
            end
        end
    end

    // A channel may nest only if no in-service bit sits at its index or above.
    always_comb begin
        above_irw = '1;
        for (int i = 0; i < N_IRQ; i++) begin
            for (int j = i; j < N_IRQ; j++) begin
                if (irw_q[j]) begin
                    above_irw[i] = 1'b0;
                end
            end
        end
    end

    assign eligible     = pending_q & mask_q & above_irw;
    assign any_eligible = |eligible;

    always_comb begin
        cand_id = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eligible[i]) begin
                cand_id = ID_WIDTH'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending / lost / mask / in-service next state
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                // A rise coinciding with the clearing ack keeps the bit set.
                pending_d[i] = rise[i] | (pending_q[i] & ~ack_sel[i]);
            end else begin
                pending_d[i] = sync2_q[i];
            end
        end
    end

    // A second rise before the first was acknowledged is recorded as lost.
    assign lost_d = cfg_we ? '0 : (lost_q | (rise & pending_q));
    assign mask_d = cfg_we ? cfg_mask : mask_q;

    // ERET retires the innermost handler before a simultaneous ack is recorded.
    assign irw_d = (int_done ? (irw_q & ~done_sel) : irw_q) | ack_sel;

    // -------------------------------------------------------------------------
    // Request FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        case (state_q)
            ST_IDLE: begin
                if (ie && any_eligible) begin
                    state_d  = ST_REQ;
                    int_id_d = cand_id;
                end
            end
            // id/vector stay frozen here whatever happens to ie, mask or
            // higher-priority arrivals until the CPU acknowledges.
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            // One dead cycle so the pipeline can flush before re-evaluating.
            ST_SERVICE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would let the synchroniser
    // stages collapse into one flop in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            lost_q    <= '0;
            mask_q    <= '1;
            irw_q     <= '0;
            state_q   <= ST_IDLE;
            int_id_q  <= '0;
        end else begin
            sync1_q   <= irq_in;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            mask_q    <= mask_d;
            irw_q     <= irw_d;
            state_q   <= state_d;
            int_id_q  <= int_id_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Decoded straight from registers so reset takes effect without a clock.
    assign int_req = (state_q == ST_REQ);
    assign int_id  = int_id_q;
    assign int_vec = VEC_BASE + VEC_WIDTH'(int_id_q) * VEC_STRIDE;
    assign irw     = irw_q;
    assign pending = pending_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that keeps the
// in-service set as a stack of channel numbers.
module tb_irq_controller;

    localparam int         N    = 4;
    localparam logic [3:0] EDGE = 4'b0111;  // channel 3 is level-sensitive

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_in = '0;
    logic        ie = 1'b0;
    logic        int_ack = 1'b0;
    logic        int_done = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_mask = '0;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [3:0]  irw;
    logic [3:0]  pending;
    logic [3:0]  lost;

    irq_controller #(
        .N_IRQ     (N),
        .ID_WIDTH  (2),
        .VEC_WIDTH (32),
        .VEC_BASE  (32'h0000_0800),
        .VEC_STRIDE(32'h0000_0100),
        .EDGE_MASK (EDGE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .ie      (ie),
        .int_ack (int_ack),
        .int_done(int_done),
        .cfg_we  (cfg_we),
        .cfg_mask(cfg_mask),
        .int_req (int_req),
        .int_id  (int_id),
        .int_vec (int_vec),
        .irw     (irw),
        .pending (pending),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    bit [3:0] m_dly0, m_dly1, m_dly2;  // input as seen 1, 2 and 3 edges ago
    bit [3:0] m_pend, m_lost, m_mask;
    int       m_stack[$];              // channels in service, innermost last
    bit       m_req, m_svc;
    int       m_id;

    function automatic int stack_max();
        int top = -1;
        foreach (m_stack[k]) if (m_stack[k] > top) top = m_stack[k];
        return top;
    endfunction

    function automatic bit [3:0] exp_irw();
        bit [3:0] r = '0;
        foreach (m_stack[k]) r[m_stack[k]] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_dly0 = '0; m_dly1 = '0; m_dly2 = '0;
        m_pend = '0; m_lost = '0; m_mask = '1;
        m_stack.delete();
        m_req = 0; m_svc = 0; m_id = 0;
    endtask

    task automatic model_step();
        bit [3:0] rise, pend_n, lost_n;
        bit       ack;
        int       top, cand;
        rise = m_dly1 & ~m_dly2 & EDGE;
        ack  = int_ack && m_req;
        top  = stack_max();
        cand = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_mask[i] && i > top) cand = i;
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) pend_n[i] = rise[i] | (m_pend[i] & !(ack && m_id == i));
            else         pend_n[i] = m_dly1[i];
        end
        lost_n = cfg_we ? 4'b0 : (m_lost | (rise & m_pend));
        if (int_done && m_stack.size() > 0) begin
            for (int k = 0; k < m_stack.size(); k++)
                if (m_stack[k] == top) begin m_stack.delete(k); break; end
        end
        if (ack) m_stack.push_back(m_id);
        if (m_svc)          m_svc = 0;
        else if (m_req) begin
            if (ack) begin m_req = 0; m_svc = 1; end
        end else if (ie && cand >= 0) begin
            m_req = 1; m_id = cand;
        end
        if (cfg_we) m_mask = cfg_mask;
        m_pend = pend_n;
        m_lost = lost_n;
        m_dly2 = m_dly1; m_dly1 = m_dly0; m_dly0 = irq_in;
    endtask

    task automatic compare_all();
        check("int_req", 32'(int_req), 32'(m_req));
        check("int_id",  32'(int_id),  32'(m_id));
        check("int_vec", int_vec, 32'h800 + 32'(m_id) * 32'h100);
        check("irw",     32'(irw),     32'(exp_irw()));
        check("pending", 32'(pending), 32'(m_pend));
        check("lost",    32'(lost),    32'(m_lost));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        model_reset();
        repeat (2) cycle();
        rst = 0;
        ie  = 1;

        // Single edge on ch1: request exactly 4 clocks after the rise.
        irq_in[1] = 1;
        repeat (3) cycle();
        check("lat3_req", 32'(int_req), 32'd0);
        cycle();
        check("lat4_req", 32'(int_req), 32'd1);
        check("lat4_id",  32'(int_id),  32'd1);
        check("lat4_vec", int_vec, 32'h900);
        int_ack = 1; cycle(); int_ack = 0;
        check("ack_irw",  32'(irw),     32'b0010);
        check("ack_pend", 32'(pending), 32'b0000);
        check("ack_req",  32'(int_req), 32'd0);
        int_done = 1; irq_in[1] = 0; cycle(); int_done = 0;
        check("done_irw", 32'(irw), 32'd0);

        // Simultaneous ch0 and ch2: ch2 first, ch0 after ack + done.
        irq_in[0] = 1; irq_in[2] = 1;
        repeat (4) cycle();
        check("prio_id",  32'(int_id), 32'd2);
        check("prio_vec", int_vec, 32'hA00);
        int_ack = 1;  cycle(); int_ack = 0;
        int_done = 1; cycle(); int_done = 0;
        cycle();
        check("prio2_req", 32'(int_req), 32'd1);
        check("prio2_id",  32'(int_id),  32'd0);
        check("prio2_vec", int_vec, 32'h800);
        int_ack = 1;  cycle(); int_ack = 0;
        int_done = 1; irq_in = '0; cycle(); int_done = 0;

        // Reset while requesting a level channel.
        irq_in[3] = 1;
        for (int k = 0; k < 10 && !int_req; k++) cycle();
        check("lvl_req", 32'(int_req), 32'd1);
        #2 rst = 1;
        #1;
        check("arst_req",  32'(int_req), 32'd0);
        check("arst_id",   32'(int_id),  32'd0);
        check("arst_vec",  int_vec, 32'h800);
        check("arst_irw",  32'(irw),     32'd0);
        check("arst_pend", 32'(pending), 32'd0);
        check("arst_lost", 32'(lost),    32'd0);
        model_reset();
        repeat (2) cycle();
        rst = 0;
        repeat (3) cycle();
        check("rel3_req", 32'(int_req), 32'd0);
        cycle();
        check("rel4_req", 32'(int_req), 32'd1);
        check("rel4_id",  32'(int_id),  32'd3);
        check("rel4_vec", int_vec, 32'hB00);
        int_ack = 1; cycle(); int_ack = 0;

        // Two ch1 rises while ch3 is in service: second one is lost.
        irq_in[1] = 1; repeat (2) cycle();
        irq_in[1] = 0; repeat (2) cycle();
        irq_in[1] = 1; repeat (3) cycle();
        check("lost_set", 32'(lost), 32'b0010);
        cfg_we = 1; cfg_mask = 4'b1111; cycle(); cfg_we = 0;
        check("lost_clr", 32'(lost), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            irq_in   = irq_in ^ ((($urandom % 4) == 0) ? 4'(1 << ($urandom % 4)) : 4'b0);
            ie       = ($urandom % 10) != 0;
            int_ack  = (m_req && ($urandom % 3) == 0) || (($urandom % 25) == 0);
            int_done = ($urandom % 7) == 0;
            cfg_we   = ($urandom % 40) == 0;
            cfg_mask = 4'($urandom | $urandom);
            cycle();
        end
        int_ack = 0; int_done = 0; cfg_we = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
